// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receiver.
//   rx_state_t  : receiver FSM state (IDLE, START, DATA, STOP)
//   OVERSAMPLE  : oversample ticks per serial bit
//   MID_SAMPLE  : ticks from the start edge to the middle of the start bit
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

endpackage

// File: rtl/uart_rx_tick.sv
// ----------------------------------------------------------------------------
// uart_rx_tick
// Oversample tick generator: one-cycle tick every CLK_FREQ/(BAUD*OVERSAMPLE)
// clocks (integer-truncated). A restart pulse re-phases the divider to 0 so
// sampling is aligned to the detected start edge.
// Parameters: CLK_FREQ (Hz), BAUD (bit/s)
// Ports:
//   sysclk  in  clock, rising edge
//   reset   in  synchronous active-high reset
//   restart in  clear the divider (start edge seen)
//   tick    out oversample strobe, one cycle wide
// ----------------------------------------------------------------------------
module uart_rx_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic sysclk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sysclk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Suppressed on the restart cycle so the first tick is a full DIV later.
    assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_receiver.sv
// ----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver with 16x oversampling, mid-bit sampling, frame-error
// pulse and sticky overrun flag.
// Build option: define UART_RX_DATA_INVERT_EN to invert every data bit before
// storage (start/stop polarity unchanged). Undefined: bits stored as sampled.
// Parameters: CLK_FREQ (Hz), BAUD (bit/s)
// Ports:
//   sysclk       in  clock, rising edge
//   reset        in  synchronous active-high reset
//   UART_RX      in  asynchronous serial line, idle high
//   RX_DATA      out last correctly framed byte
//   RX_VALID     out RX_DATA holds an unread byte
//   RX_ACK       in  read strobe, clears RX_VALID
//   RX_STATUS    out frame in progress
//   RX_FRAME_ERR out one-cycle pulse on a low stop bit
//   RX_OVERRUN   out sticky: byte completed while RX_VALID was high
// ----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_ACK,
    output logic       RX_STATUS,
    output logic       RX_FRAME_ERR,
    output logic       RX_OVERRUN
);

    localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] BIT_LAST = 4'(OVERSAMPLE - 1);

    rx_state_t  state, next_state;
    logic       sync1, sync2, rx_prev;
    logic       tick;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic       data_bit;
    logic       start_edge, phase_done;
    logic       restart, sample_data, byte_done, stop_bad;

    // Synchronizer, plus one more flop for falling-edge detection. Because
    // rx_prev tracks the line in every state, a line held low through STOP
    // must go high before another edge can be seen.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= UART_RX;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    assign start_edge = (state == IDLE) && rx_prev && !sync2;
    assign phase_done = tick &&
                        (tick_cnt == ((state == START) ? MID_LAST : BIT_LAST));

    uart_rx_tick #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_tick (
        .sysclk  (sysclk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // FSM state register
    always_ff @(posedge sysclk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_edge) next_state = START;
            START:   if (phase_done) next_state = sync2 ? IDLE : DATA;
            DATA:    if (phase_done && (bit_cnt == 3'd7)) next_state = STOP;
            STOP:    if (phase_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        restart     = start_edge;
        sample_data = (state == DATA) && phase_done;
        byte_done   = (state == STOP) && phase_done && sync2;
        stop_bad    = (state == STOP) && phase_done && !sync2;
        RX_STATUS   = (state != IDLE);
    end

    // Tick phase within the current bit and data bit index
    always_ff @(posedge sysclk) begin
        if (reset || start_edge || (state == IDLE)) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
        end else if (tick) begin
            tick_cnt <= phase_done ? 4'd0 : tick_cnt + 4'd1;
            if (sample_data) bit_cnt <= bit_cnt + 3'd1;
        end
    end

`ifdef UART_RX_DATA_INVERT_EN
    assign data_bit = ~sync2;
`else
    assign data_bit = sync2;
`endif

    // LSB arrives first, so shift right and insert at the MSB.
    always_ff @(posedge sysclk) begin
        if (sample_data) shift <= {data_bit, shift[7:1]};
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            RX_DATA      <= 8'h00;
            RX_VALID     <= 1'b0;
            RX_FRAME_ERR <= 1'b0;
            RX_OVERRUN   <= 1'b0;
        end else begin
            RX_FRAME_ERR <= stop_bad;
            if (byte_done) begin
                RX_DATA  <= shift;
                RX_VALID <= 1'b1;
                // An ack on the completion cycle consumes the old byte.
                if (RX_VALID && !RX_ACK) RX_OVERRUN <= 1'b1;
            end else if (RX_ACK) begin
                RX_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// ----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver. DIV = 1228800/(9600*16) = 8 clocks per
// tick, 128 clocks per bit. Byte values are expressed as the value expected in
// RX_DATA; line_of() gives the bits actually put on the wire for the build.
// ----------------------------------------------------------------------------
module tb_uart_receiver;

    localparam int CLK_FREQ = 1228800;
    localparam int BAUD     = 9600;
    localparam int BIT      = 128;

    logic       sysclk;
    logic       reset;
    logic       UART_RX;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_ACK;
    logic       RX_STATUS;
    logic       RX_FRAME_ERR;
    logic       RX_OVERRUN;

    int checks   = 0;
    int failures = 0;

    int cyc           = 0;
    int valid_rise    = 0;
    int ferr_cycles   = 0;
    int status_cycles = 0;
    logic valid_q     = 1'b0;

    uart_receiver #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .UART_RX      (UART_RX),
        .RX_DATA      (RX_DATA),
        .RX_VALID     (RX_VALID),
        .RX_ACK       (RX_ACK),
        .RX_STATUS    (RX_STATUS),
        .RX_FRAME_ERR (RX_FRAME_ERR),
        .RX_OVERRUN   (RX_OVERRUN)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Cycle-level observation, 1 time unit after each rising edge.
    always @(posedge sysclk) begin
        #1;
        cyc = cyc + 1;
        if (RX_VALID && !valid_q) valid_rise = cyc;
        valid_q = RX_VALID;
        ferr_cycles = ferr_cycles + int'(RX_FRAME_ERR);
        status_cycles = status_cycles + int'(RX_STATUS);
    end

    function automatic logic [7:0] line_of(input logic [7:0] b);
`ifdef UART_RX_DATA_INVERT_EN
        return ~b;
`else
        return b;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int bits);
        repeat (bits * BIT) @(negedge sysclk);
    endtask

    // Called at a falling edge; drives start, 8 bits LSB first, stop.
    task automatic send_frame(input logic [7:0] lb, input logic stop, input logic hold);
        UART_RX = 1'b0;
        repeat (BIT) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            UART_RX = lb[i];
            repeat (BIT) @(negedge sysclk);
        end
        UART_RX = stop;
        repeat (BIT) @(negedge sysclk);
        if (!hold) UART_RX = 1'b1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
    endtask

    initial begin
        int c0, lat, s0, f0, d;
        logic [7:0] lb;

        reset   = 1'b1;
        UART_RX = 1'b1;
        RX_ACK  = 1'b0;
        repeat (4) @(negedge sysclk);
        chk("reset_data",     32'(RX_DATA),      32'h00);
        chk("reset_valid",    32'(RX_VALID),     32'h0);
        chk("reset_status",   32'(RX_STATUS),    32'h0);
        chk("reset_ferr",     32'(RX_FRAME_ERR), 32'h0);
        chk("reset_overrun",  32'(RX_OVERRUN),   32'h0);
        reset = 1'b0;
        repeat (8) @(negedge sysclk);

        // 0x55; valid expected 3 + 152*8 = 1219 clocks after the line falls
        c0 = cyc;
        send_frame(line_of(8'h55), 1'b1, 1'b0);
        lat = valid_rise - c0;
        idle(1);
        chk("b55_data",    32'(RX_DATA),  32'h55);
        chk("b55_valid",   32'(RX_VALID), 32'h1);
        chk("b55_latency_in_window", 32'(lat >= 1208 && lat <= 1227), 32'h1);
        chk("b55_status_idle", 32'(RX_STATUS), 32'h0);

        RX_ACK = 1'b1;
        @(negedge sysclk);
        RX_ACK = 1'b0;
        chk("ack_clears_valid", 32'(RX_VALID), 32'h0);
        RX_ACK = 1'b1;
        @(negedge sysclk);
        RX_ACK = 1'b0;
        chk("ack_no_effect_valid", 32'(RX_VALID), 32'h0);
        chk("ack_no_effect_data",  32'(RX_DATA),  32'h55);

        // 50-clock glitch: START lasts ~64 clocks, must be <= 9 ticks (72)
        s0 = status_cycles;
        UART_RX = 1'b0;
        repeat (50) @(negedge sysclk);
        UART_RX = 1'b1;
        repeat (200) @(negedge sysclk);
        d = status_cycles - s0;
        chk("glitch_status_seen",  32'(d > 0), 32'h1);
        chk("glitch_status_short", 32'(d <= 72), 32'h1);
        chk("glitch_valid",        32'(RX_VALID), 32'h0);
        chk("glitch_back_idle",    32'(RX_STATUS), 32'h0);

        // 0x3C with low stop bit, then line held low (break)
        f0 = ferr_cycles;
        send_frame(line_of(8'h3C), 1'b0, 1'b1);
        s0 = status_cycles;
        idle(3);
        chk("break_no_restart", 32'(status_cycles - s0), 32'h0);
        UART_RX = 1'b1;
        idle(2);
        chk("ferr_one_cycle", 32'(ferr_cycles - f0), 32'h1);
        chk("ferr_valid",     32'(RX_VALID), 32'h0);
        chk("ferr_data_kept", 32'(RX_DATA),  32'h55);
        chk("ferr_status",    32'(RX_STATUS), 32'h0);

        // 0xA3 (wire carries ~0xA3 in the inverting build)
        send_frame(line_of(8'hA3), 1'b1, 1'b0);
        idle(1);
        chk("bA3_data",  32'(RX_DATA),  32'hA3);
        chk("bA3_valid", 32'(RX_VALID), 32'h1);

        // Overrun without ack
        pulse_reset();
        send_frame(line_of(8'h11), 1'b1, 1'b0);
        idle(1);
        send_frame(line_of(8'h22), 1'b1, 1'b0);
        idle(1);
        chk("ovr_data",    32'(RX_DATA),    32'h22);
        chk("ovr_valid",   32'(RX_VALID),   32'h1);
        chk("ovr_flag",    32'(RX_OVERRUN), 32'h1);
        idle(2);
        chk("ovr_sticky",  32'(RX_OVERRUN), 32'h1);
        pulse_reset();
        chk("ovr_reset_clears", 32'(RX_OVERRUN), 32'h0);

        // Ack exactly on the second completion cycle
        send_frame(line_of(8'h11), 1'b1, 1'b0);
        idle(1);
        chk("ack_race_first_valid", 32'(RX_VALID), 32'h1);
        fork
            send_frame(line_of(8'h22), 1'b1, 1'b0);
            begin
                repeat (lat - 1) @(negedge sysclk);
                RX_ACK = 1'b1;
                @(negedge sysclk);
                RX_ACK = 1'b0;
            end
        join
        idle(1);
        chk("ack_race_data",    32'(RX_DATA),    32'h22);
        chk("ack_race_valid",   32'(RX_VALID),   32'h1);
        chk("ack_race_overrun", 32'(RX_OVERRUN), 32'h0);

        // Reset in the middle of data bit 4 of 0xFF
        lb = line_of(8'hFF);
        UART_RX = 1'b0;
        repeat (BIT) @(negedge sysclk);
        for (int i = 0; i < 4; i++) begin
            UART_RX = lb[i];
            repeat (BIT) @(negedge sysclk);
        end
        UART_RX = lb[4];
        repeat (BIT / 2) @(negedge sysclk);
        chk("midframe_busy", 32'(RX_STATUS), 32'h1);
        reset   = 1'b1;
        UART_RX = 1'b1;
        repeat (2) @(negedge sysclk);
        chk("midrst_data",    32'(RX_DATA),      32'h00);
        chk("midrst_valid",   32'(RX_VALID),     32'h0);
        chk("midrst_status",  32'(RX_STATUS),    32'h0);
        chk("midrst_ferr",    32'(RX_FRAME_ERR), 32'h0);
        chk("midrst_overrun", 32'(RX_OVERRUN),   32'h0);
        reset = 1'b0;
        idle(4);
        chk("midrst_no_partial", 32'(RX_VALID), 32'h0);
        send_frame(line_of(8'h0F), 1'b1, 1'b0);
        idle(1);
        chk("b0F_data",  32'(RX_DATA),  32'h0F);
        chk("b0F_valid", 32'(RX_VALID), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 SHALL have port sysclk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port UART_RX, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port RX_DATA, output, 8, last correctly framed byte.
REQ-007 SHALL have port RX_VALID, output, 1, RX_DATA holds an unread byte.
REQ-008 SHALL have port RX_ACK, input, 1, consumer read strobe; clears RX_VALID.
REQ-009 SHALL have port RX_STATUS, output, 1, high while a frame is in progress (state not IDLE).
REQ-010 SHALL have port RX_FRAME_ERR, output, 1, one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port RX_OVERRUN, output, 1, sticky flag; byte completed while RX_VALID was high.

Function
REQ-012 SHALL pass UART_RX through a 2-flop synchronizer before any use.
REQ-013 SHALL generate a 16x oversample tick every DIV = CLK_FREQ/(BAUD*16) clocks, integer-truncated (651 at defaults); the counter restarts at 0 on start-edge detection.
REQ-014 SHALL implement FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-015 IDLE: on a synchronized high-to-low transition, go to START and clear the tick-phase counter.
REQ-016 START: after 8 ticks, sample the line; if low go to DATA, if high (glitch) return to IDLE with no output change.
REQ-017 DATA: sample every 16 ticks, 8 bits, LSB first, into a shift register; after bit 7 go to STOP.
REQ-018 STOP: after 16 ticks, sample; if high, load RX_DATA and set RX_VALID the next cycle; if low, pulse RX_FRAME_ERR, leave RX_DATA/RX_VALID unchanged; return to IDLE in both cases.
REQ-019 After STOP, a new start SHALL be recognised only after the line has been sampled high in IDLE (no edge on a held-low break).
REQ-020 RX_VALID SHALL clear the cycle after RX_ACK is high; RX_ACK while RX_VALID is low has no effect.
REQ-021 Byte completion coinciding with RX_ACK SHALL load the new byte, keep RX_VALID high, and not set RX_OVERRUN.
REQ-022 Byte completion with RX_VALID high and no RX_ACK SHALL overwrite RX_DATA and set RX_OVERRUN, which is cleared only by reset.

Reset
REQ-023 Reset SHALL force state IDLE, RX_DATA=0x00, RX_VALID=0, RX_STATUS=0, RX_FRAME_ERR=0, RX_OVERRUN=0, counters=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abandon the frame with no partial byte delivered.

Configuration
REQ-025 Macro UART_RX_DATA_INVERT_EN defined: each data bit SHALL be inverted before storage (pairs with the team's inverted-data transmitter); start/stop polarity unchanged.
REQ-026 Macro undefined: data bits SHALL be stored as sampled.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state type (IDLE, START, DATA, STOP) and constants OVERSAMPLE=16 and MID_SAMPLE=8.
REQ-028 Tick generation SHALL be sub-module uart_rx_tick (parameters CLK_FREQ, BAUD; inputs sysclk, reset, restart; output tick).

Verification
REQ-029 Defaults, macro off, send 0x55 (bit period 10416 clocks) -> RX_DATA=0x55, RX_VALID high within 9.5 bit periods +/-1 tick of the start edge.
REQ-030 Macro on, line carries bits of ~0xA3 -> RX_DATA=0xA3.
REQ-031 50-clock low glitch on idle line -> returns to IDLE, RX_VALID stays 0, RX_STATUS high no longer than 9 ticks.
REQ-032 Send 0x3C with stop bit low -> one-cycle RX_FRAME_ERR, RX_VALID stays 0, RX_DATA unchanged.
REQ-033 Send 0x11 then 0x22 without RX_ACK -> RX_DATA=0x22, RX_OVERRUN=1; repeat after reset with RX_ACK pulsed at the second completion cycle -> RX_OVERRUN=0.
REQ-034 Assert reset during DATA bit 4 of 0xFF -> all outputs at reset values; next frame 0x0F received correctly.
